id_ex_stage_reg: RTL and testbench

- Decode-to-execute pipeline register. Sits directly downstream of the main control decoder and the register-file read.
- Captures the decoder control bundle, operands, register specifiers, immediate, funct and PC+4 for the EX stage.
- Supports stall (hold) and flush (bubble injection) requested by the hazard unit, and tracks per-stage validity.
- Keeps a saturating count of inserted bubbles for debug.

---
 rtl/pipe_pkg.sv | 29 ++
 rtl/pipe_en_clr_reg.sv | 28 ++
 rtl/id_ex_stage_reg.sv | 130 +++++++++++++
 tb/tb_id_ex_stage_reg.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline types: decoder control bundle, ALU operation classes and opcodes.
package pipe_pkg;

    typedef struct packed {
        logic       rfwe;
        logic       rfdsel;
        logic       aluinsel;
        logic       branch;
        logic       dmwe;
        logic       mtorfsel;
        logic       jump;
        logic [1:0] aluop;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_SLT   = 2'b11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

endpackage

// File: rtl/pipe_en_clr_reg.sv
// Pipeline flop with async active-low reset, synchronous clear and load enable.
module pipe_en_clr_reg #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] q_q;

    // Clear outranks enable so a flush still bubbles a stalled stage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q <= '0;
        end else if (clr_i) begin
            q_q <= '0;
        end else if (en_i) begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with stall, flush, invalid-decode sanitising and a bubble counter.
module id_ex_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned DW    = 32,
    parameter int unsigned RW    = 5,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_e,
    input  logic             flush_e,
    input  logic             valid_d,
    input  logic             rfwe_d,
    input  logic             rfdsel_d,
    input  logic             aluinsel_d,
    input  logic             branch_d,
    input  logic             dmwe_d,
    input  logic             mtorfsel_d,
    input  logic             jump_d,
    input  logic [1:0]       aluop_d,
    input  logic [5:0]       funct_d,
    input  logic [DW-1:0]    rd1_d,
    input  logic [DW-1:0]    rd2_d,
    input  logic [RW-1:0]    rs_d,
    input  logic [RW-1:0]    rt_d,
    input  logic [RW-1:0]    rd_d,
    input  logic [DW-1:0]    imm_d,
    input  logic [DW-1:0]    pcplus4_d,
    output logic             valid_e,
    output logic             rfwe_e,
    output logic             rfdsel_e,
    output logic             aluinsel_e,
    output logic             branch_e,
    output logic             dmwe_e,
    output logic             mtorfsel_e,
    output logic             jump_e,
    output logic [1:0]       aluop_e,
    output logic [5:0]       funct_e,
    output logic [DW-1:0]    rd1_e,
    output logic [DW-1:0]    rd2_e,
    output logic [DW-1:0]    imm_e,
    output logic [DW-1:0]    pcplus4_e,
    output logic [RW-1:0]    rs_e,
    output logic [RW-1:0]    rt_e,
    output logic [RW-1:0]    rd_e,
    output logic [CNT_W-1:0] bubble_cnt
);

    localparam int unsigned CtrlW = $bits(ctrl_t) + 1;
    localparam int unsigned DataW = 6 + 4 * DW + 3 * RW;

    ctrl_t             ctrl_in;
    ctrl_t             ctrl_d;
    ctrl_t             ctrl_e;
    logic [DataW-1:0]  data_d;
    logic [DataW-1:0]  data_q;
    logic [CNT_W-1:0]  bubble_cnt_d;
    logic [CNT_W-1:0]  bubble_cnt_q;
    logic              load_en;

    always_comb begin
        ctrl_in          = CTRL_NOP;
        ctrl_in.rfwe     = rfwe_d;
        ctrl_in.rfdsel   = rfdsel_d;
        ctrl_in.aluinsel = aluinsel_d;
        ctrl_in.branch   = branch_d;
        ctrl_in.dmwe     = dmwe_d;
        ctrl_in.mtorfsel = mtorfsel_d;
        ctrl_in.jump     = jump_d;
        ctrl_in.aluop    = aluop_d;
    end

    // An invalid decode slot enters EX as a bubble so no side-effecting control escapes.
    assign ctrl_d  = valid_d ? ctrl_in : CTRL_NOP;
    assign load_en = ~stall_e;
    assign data_d  = {funct_d, rd1_d, rd2_d, imm_d, pcplus4_d, rs_d, rt_d, rd_d};

    pipe_en_clr_reg #(
        .Width (CtrlW)
    ) u_ctrl_reg (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .en_i   (load_en),
        .clr_i  (flush_e),
        .d_i    ({valid_d, ctrl_d}),
        .q_o    ({valid_e, ctrl_e})
    );

    pipe_en_clr_reg #(
        .Width (DataW)
    ) u_data_reg (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .en_i   (load_en),
        .clr_i  (flush_e),
        .d_i    (data_d),
        .q_o    (data_q)
    );

    assign rfwe_e     = ctrl_e.rfwe;
    assign rfdsel_e   = ctrl_e.rfdsel;
    assign aluinsel_e = ctrl_e.aluinsel;
    assign branch_e   = ctrl_e.branch;
    assign dmwe_e     = ctrl_e.dmwe;
    assign mtorfsel_e = ctrl_e.mtorfsel;
    assign jump_e     = ctrl_e.jump;
    assign aluop_e    = ctrl_e.aluop;

    assign {funct_e, rd1_e, rd2_e, imm_e, pcplus4_e, rs_e, rt_e, rd_e} = data_q;

    // Only flushes count; sanitised invalid loads are not hazard-unit bubbles.
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (flush_e && (bubble_cnt_q != {CNT_W{1'b1}})) begin
            bubble_cnt_d = bubble_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_q <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Self-checking bench for id_ex_stage_reg: behavioural model, per-cycle compare, directed vectors.
module tb_id_ex_stage_reg;

    logic        clk;
    logic        rst_n;
    logic        stall_e, flush_e, valid_d;
    logic        rfwe_d, rfdsel_d, aluinsel_d, branch_d, dmwe_d, mtorfsel_d, jump_d;
    logic [1:0]  aluop_d;
    logic [5:0]  funct_d;
    logic [31:0] rd1_d, rd2_d, imm_d, pcplus4_d;
    logic [4:0]  rs_d, rt_d, rd_d;

    logic        valid_e, rfwe_e, rfdsel_e, aluinsel_e, branch_e, dmwe_e, mtorfsel_e, jump_e;
    logic [1:0]  aluop_e;
    logic [5:0]  funct_e;
    logic [31:0] rd1_e, rd2_e, imm_e, pcplus4_e;
    logic [4:0]  rs_e, rt_e, rd_e;
    logic [15:0] bubble_cnt;

    logic        s_valid_e, s_rfwe_e, s_rfdsel_e, s_aluinsel_e, s_branch_e, s_dmwe_e;
    logic        s_mtorfsel_e, s_jump_e;
    logic [1:0]  s_aluop_e;
    logic [5:0]  s_funct_e;
    logic [31:0] s_rd1_e, s_rd2_e, s_imm_e, s_pcplus4_e;
    logic [4:0]  s_rs_e, s_rt_e, s_rd_e;
    logic [1:0]  s_bubble_cnt;

    int errors = 0;
    int checks = 0;

    id_ex_stage_reg dut (
        .clk(clk), .rst_n(rst_n), .stall_e(stall_e), .flush_e(flush_e), .valid_d(valid_d),
        .rfwe_d(rfwe_d), .rfdsel_d(rfdsel_d), .aluinsel_d(aluinsel_d), .branch_d(branch_d),
        .dmwe_d(dmwe_d), .mtorfsel_d(mtorfsel_d), .jump_d(jump_d), .aluop_d(aluop_d),
        .funct_d(funct_d), .rd1_d(rd1_d), .rd2_d(rd2_d), .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d),
        .imm_d(imm_d), .pcplus4_d(pcplus4_d),
        .valid_e(valid_e), .rfwe_e(rfwe_e), .rfdsel_e(rfdsel_e), .aluinsel_e(aluinsel_e),
        .branch_e(branch_e), .dmwe_e(dmwe_e), .mtorfsel_e(mtorfsel_e), .jump_e(jump_e),
        .aluop_e(aluop_e), .funct_e(funct_e), .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_e(imm_e),
        .pcplus4_e(pcplus4_e), .rs_e(rs_e), .rt_e(rt_e), .rd_e(rd_e), .bubble_cnt(bubble_cnt)
    );

    id_ex_stage_reg #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .stall_e(stall_e), .flush_e(flush_e), .valid_d(valid_d),
        .rfwe_d(rfwe_d), .rfdsel_d(rfdsel_d), .aluinsel_d(aluinsel_d), .branch_d(branch_d),
        .dmwe_d(dmwe_d), .mtorfsel_d(mtorfsel_d), .jump_d(jump_d), .aluop_d(aluop_d),
        .funct_d(funct_d), .rd1_d(rd1_d), .rd2_d(rd2_d), .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d),
        .imm_d(imm_d), .pcplus4_d(pcplus4_d),
        .valid_e(s_valid_e), .rfwe_e(s_rfwe_e), .rfdsel_e(s_rfdsel_e),
        .aluinsel_e(s_aluinsel_e), .branch_e(s_branch_e), .dmwe_e(s_dmwe_e),
        .mtorfsel_e(s_mtorfsel_e), .jump_e(s_jump_e), .aluop_e(s_aluop_e),
        .funct_e(s_funct_e), .rd1_e(s_rd1_e), .rd2_e(s_rd2_e), .imm_e(s_imm_e),
        .pcplus4_e(s_pcplus4_e), .rs_e(s_rs_e), .rt_e(s_rt_e), .rd_e(s_rd_e),
        .bubble_cnt(s_bubble_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: what EX must hold after each edge, derived from the stage rules.
    logic        m_valid;
    logic [8:0]  m_ctrl;
    logic [5:0]  m_funct;
    logic [31:0] m_rd1, m_rd2, m_imm, m_pc;
    logic [4:0]  m_rs, m_rt, m_rd;
    int          m_cnt16, m_cnt2;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 0; m_ctrl = 0; m_funct = 0; m_rd1 = 0; m_rd2 = 0; m_imm = 0; m_pc = 0;
            m_rs = 0; m_rt = 0; m_rd = 0; m_cnt16 = 0; m_cnt2 = 0;
        end else if (flush_e) begin
            m_valid = 0; m_ctrl = 0; m_funct = 0; m_rd1 = 0; m_rd2 = 0; m_imm = 0; m_pc = 0;
            m_rs = 0; m_rt = 0; m_rd = 0;
            m_cnt16 = (m_cnt16 == 65535) ? 65535 : m_cnt16 + 1;
            m_cnt2  = (m_cnt2 == 3) ? 3 : m_cnt2 + 1;
        end else if (!stall_e) begin
            m_valid = valid_d;
            if (valid_d)
                m_ctrl = {rfwe_d, rfdsel_d, aluinsel_d, branch_d, dmwe_d, mtorfsel_d, jump_d,
                          aluop_d};
            else
                m_ctrl = 0;
            m_funct = funct_d; m_rd1 = rd1_d; m_rd2 = rd2_d; m_imm = imm_d; m_pc = pcplus4_d;
            m_rs = rs_d; m_rt = rt_d; m_rd = rd_d;
        end
    end

    function automatic logic [255:0] model_bundle();
        return {m_valid, m_ctrl, m_funct, m_rd1, m_rd2, m_imm, m_pc, m_rs, m_rt, m_rd};
    endfunction

    // Per-cycle compare, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("valid_e", valid_e, m_valid);
            chk("ctrl_e", {rfwe_e, rfdsel_e, aluinsel_e, branch_e, dmwe_e, mtorfsel_e, jump_e,
                           aluop_e}, m_ctrl);
            chk("funct_e", funct_e, m_funct);
            chk("rd1_e", rd1_e, m_rd1);
            chk("rd2_e", rd2_e, m_rd2);
            chk("imm_e", imm_e, m_imm);
            chk("pcplus4_e", pcplus4_e, m_pc);
            chk("specs_e", {rs_e, rt_e, rd_e}, {m_rs, m_rt, m_rd});
            chk("bubble_cnt", bubble_cnt, m_cnt16);
            chk("sat_bundle", {s_valid_e, s_rfwe_e, s_rfdsel_e, s_aluinsel_e, s_branch_e,
                               s_dmwe_e, s_mtorfsel_e, s_jump_e, s_aluop_e, s_funct_e,
                               s_rd1_e, s_rd2_e, s_imm_e, s_pcplus4_e, s_rs_e, s_rt_e, s_rd_e},
                model_bundle());
            chk("sat_bubble_cnt", s_bubble_cnt, m_cnt2);
        end
    end

    task automatic clear_d();
        valid_d = 0; rfwe_d = 0; rfdsel_d = 0; aluinsel_d = 0; branch_d = 0; dmwe_d = 0;
        mtorfsel_d = 0; jump_d = 0; aluop_d = 0; funct_d = 0; rd1_d = 0; rd2_d = 0;
        imm_d = 0; pcplus4_d = 0; rs_d = 0; rt_d = 0; rd_d = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 0; stall_e = 0; flush_e = 0;
        clear_d();
        #12;
        chk("rst_valid", valid_e, 1'b0);
        chk("rst_cnt", bubble_cnt, 16'd0);
        rst_n = 1;
        step();

        // R-type then an asynchronous reset between edges.
        valid_d = 1; rfwe_d = 1; rfdsel_d = 1; aluop_d = 2'b10; rd1_d = 32'h12345678;
        funct_d = 6'h20; rs_d = 5'd1; rt_d = 5'd2; rd_d = 5'd3;
        step();
        chk("rtype_valid", valid_e, 1'b1);
        chk("rtype_rd1", rd1_e, 32'h12345678);
        #1 rst_n = 0;
        #1;
        chk("arst_valid", valid_e, 1'b0);
        chk("arst_rfwe", rfwe_e, 1'b0);
        chk("arst_rd1", rd1_e, 32'h0);
        chk("arst_aluop", aluop_e, 2'b00);
        chk("arst_cnt", bubble_cnt, 16'd0);
        #2 rst_n = 1;

        // lw
        clear_d();
        valid_d = 1; rfwe_d = 1; aluinsel_d = 1; mtorfsel_d = 1; aluop_d = 2'b00;
        imm_d = 32'hFFFFFFFC; pcplus4_d = 32'h00000008; rs_d = 5'd4; rt_d = 5'd5;
        step();
        chk("lw_valid", valid_e, 1'b1);
        chk("lw_imm", imm_e, 32'hFFFFFFFC);
        chk("lw_pc", pcplus4_e, 32'h00000008);
        chk("lw_mtorfsel", mtorfsel_e, 1'b1);

        // sw, then three stalled cycles with changing inputs.
        clear_d();
        valid_d = 1; dmwe_d = 1; aluinsel_d = 1; rd2_d = 32'hCAFEF00D; imm_d = 32'h4;
        pcplus4_d = 32'hC;
        step();
        chk("sw_dmwe", dmwe_e, 1'b1);
        stall_e = 1;
        for (int i = 0; i < 3; i++) begin
            rd2_d = $urandom; dmwe_d = 0; rfwe_d = 1; imm_d = $urandom;
            step();
            chk("stall_dmwe", dmwe_e, 1'b1);
            chk("stall_rd2", rd2_e, 32'hCAFEF00D);
            chk("stall_cnt", bubble_cnt, 16'd0);
        end
        stall_e = 0;

        // beq in EX, then stall and flush together.
        clear_d();
        valid_d = 1; branch_d = 1; aluop_d = 2'b01; rd1_d = 32'h5; rd2_d = 32'h5; imm_d = 32'h3;
        step();
        chk("beq_branch", branch_e, 1'b1);
        stall_e = 1; flush_e = 1;
        step();
        chk("flush_valid", valid_e, 1'b0);
        chk("flush_branch", branch_e, 1'b0);
        chk("flush_aluop", aluop_e, 2'b00);
        chk("flush_data", {rd1_e, rd2_e, imm_e}, 96'h0);
        chk("flush_cnt", bubble_cnt, 16'd1);
        stall_e = 0; flush_e = 0;

        // Invalid decode slot with dangerous controls.
        clear_d();
        valid_d = 0; rfwe_d = 1; jump_d = 1;
        step();
        chk("inv_valid", valid_e, 1'b0);
        chk("inv_rfwe", rfwe_e, 1'b0);
        chk("inv_jump", jump_e, 1'b0);
        chk("inv_cnt", bubble_cnt, 16'd1);

        // Reset while stalled, then four flushes for saturation.
        stall_e = 1;
        rst_n = 0;
        #2 rst_n = 1;
        stall_e = 0; flush_e = 1;
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("sat_cnt2", s_bubble_cnt, (i > 3) ? 2'd3 : 2'(i));
            chk("sat_cnt16", bubble_cnt, 16'(i));
        end
        flush_e = 0;

        // Mixed traffic, checked by the per-cycle compare.
        for (int i = 0; i < 40; i++) begin
            valid_d = ($urandom_range(0, 3) != 0);
            {rfwe_d, rfdsel_d, aluinsel_d, branch_d, dmwe_d, mtorfsel_d, jump_d} = 7'($urandom);
            aluop_d = 2'($urandom); funct_d = 6'($urandom);
            rd1_d = $urandom; rd2_d = $urandom; imm_d = $urandom; pcplus4_d = $urandom;
            rs_d = 5'($urandom); rt_d = 5'($urandom); rd_d = 5'($urandom);
            stall_e = ($urandom_range(0, 3) == 0);
            flush_e = ($urandom_range(0, 5) == 0);
            step();
        end
        stall_e = 0; flush_e = 0;
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
